// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared constants for the I2C transaction arbiter: field widths, status codes, FSM states.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;
    localparam int unsigned STAT_W     = 2;

    localparam logic [STAT_W-1:0] STAT_OK      = 2'b00;
    localparam logic [STAT_W-1:0] STAT_NACK    = 2'b01;
    localparam logic [STAT_W-1:0] STAT_TIMEOUT = 2'b10;

    localparam int unsigned ST_W = 3;
    typedef logic [ST_W-1:0] arb_state_t;

    localparam arb_state_t ST_IDLE      = 3'd0;
    localparam arb_state_t ST_ISSUE     = 3'd1;
    localparam arb_state_t ST_WAIT_BUSY = 3'd2;
    localparam arb_state_t ST_WAIT_DONE = 3'd3;
    localparam arb_state_t ST_RESP      = 3'd4;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and engine-side signals of the arbiter, bundled as one bus.
interface i2c_txn_arbiter_if
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_rw;
    logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [I2C_DATA_W-1:0]         rsp_rdata;
    logic [STAT_W-1:0]             rsp_status;

    logic                          m_start;
    logic [I2C_ADDR_W-1:0]         m_addr;
    logic                          m_rw;
    logic [I2C_DATA_W-1:0]         m_wdata;
    logic                          m_abort;
    logic                          m_busy;
    logic                          m_done;
    logic                          m_nack;
    logic [I2C_DATA_W-1:0]         m_rdata;

    // Arbiter view.
    modport slave (
        input  req_valid, req_addr, req_rw, req_wdata, rsp_ready,
               m_busy, m_done, m_nack, m_rdata,
        output req_gnt, rsp_valid, rsp_rdata, rsp_status,
               m_start, m_addr, m_rw, m_wdata, m_abort
    );

    // Environment view: requesters plus engine.
    modport master (
        output req_valid, req_addr, req_rw, req_wdata, rsp_ready,
               m_busy, m_done, m_nack, m_rdata,
        input  req_gnt, rsp_valid, rsp_rdata, rsp_status,
               m_start, m_addr, m_rw, m_wdata, m_abort
    );

endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request after i_ptr, with wrap-around.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt_c,
    output logic [IDX_W-1:0]   o_idx_c
);

    logic        w_found;
    int unsigned w_j;

    always_comb begin
        o_gnt_c = '0;
        o_idx_c = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_j = (32'(i_ptr) + k) % NUM_REQ;
            if (i_en && !w_found && i_req[IDX_W'(w_j)]) begin
                w_found                = 1'b1;
                o_gnt_c[IDX_W'(w_j)]   = 1'b1;
                o_idx_c                = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C byte engine among NUM_REQ requesters: round-robin grant,
// single outstanding transaction, timeout supervision, per-requester response.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TO_W           = 13
) (
    input  logic              clk,
    input  logic              reset,
    i2c_txn_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
        $error("i2c_txn_arbiter: NUM_REQ must be in 2..8");
    end
    if ((64'(1) << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_to_w
        $error("i2c_txn_arbiter: TO_W too narrow for TIMEOUT_CYCLES");
    end

    arb_state_t            r_state,   nxt_state;
    logic [IDX_W-1:0]      r_ptr,     nxt_ptr;
    logic [TO_W-1:0]       r_cnt,     nxt_cnt;
    logic [NUM_REQ-1:0]    r_gnt,     nxt_gnt;
    logic                  r_start,   nxt_start;
    logic                  r_abort,   nxt_abort;
    logic [I2C_ADDR_W-1:0] r_m_addr,  nxt_m_addr;
    logic                  r_m_rw,    nxt_m_rw;
    logic [I2C_DATA_W-1:0] r_m_wdata, nxt_m_wdata;
    logic [NUM_REQ-1:0]    r_rsp_valid, nxt_rsp_valid;
    logic [I2C_DATA_W-1:0] r_rdata,   nxt_rdata;
    logic [STAT_W-1:0]     r_status,  nxt_status;

    logic                  w_arb_en;
    logic [NUM_REQ-1:0]    w_arb_gnt;
    logic [IDX_W-1:0]      w_arb_idx;
    logic [NUM_REQ-1:0]    w_ptr_onehot;

    // Arbitration only while idle and the engine is free.
    assign w_arb_en     = (r_state == ST_IDLE) && !bus.m_busy;
    assign w_ptr_onehot = NUM_REQ'(1) << r_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_arb_en),
        .o_gnt_c (w_arb_gnt),
        .o_idx_c (w_arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_start     <= 1'b0;
            r_abort     <= 1'b0;
            r_m_addr    <= '0;
            r_m_rw      <= 1'b0;
            r_m_wdata   <= '0;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
            r_status    <= STAT_OK;
        end else begin
            r_state     <= nxt_state;
            r_ptr       <= nxt_ptr;
            r_cnt       <= nxt_cnt;
            r_gnt       <= nxt_gnt;
            r_start     <= nxt_start;
            r_abort     <= nxt_abort;
            r_m_addr    <= nxt_m_addr;
            r_m_rw      <= nxt_m_rw;
            r_m_wdata   <= nxt_m_wdata;
            r_rsp_valid <= nxt_rsp_valid;
            r_rdata     <= nxt_rdata;
            r_status    <= nxt_status;
        end
    end

    // Next-state and next-output logic; pulses default low, latched fields hold.
    always_comb begin
        nxt_state     = r_state;
        nxt_ptr       = r_ptr;
        nxt_cnt       = r_cnt;
        nxt_gnt       = '0;
        nxt_start     = 1'b0;
        nxt_abort     = 1'b0;
        nxt_m_addr    = r_m_addr;
        nxt_m_rw      = r_m_rw;
        nxt_m_wdata   = r_m_wdata;
        nxt_rsp_valid = r_rsp_valid;
        nxt_rdata     = r_rdata;
        nxt_status    = r_status;

        case (r_state)
            ST_IDLE: begin
                if (|w_arb_gnt) begin
                    nxt_gnt     = w_arb_gnt;
                    nxt_ptr     = w_arb_idx;
                    nxt_m_addr  = bus.req_addr[32'(w_arb_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                    nxt_m_rw    = bus.req_rw[w_arb_idx];
                    nxt_m_wdata = bus.req_wdata[32'(w_arb_idx)*I2C_DATA_W +: I2C_DATA_W];
                    nxt_state   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                nxt_start = 1'b1;
                nxt_cnt   = '0;
                nxt_state = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                // m_done takes precedence over a timeout in the same cycle.
                if (bus.m_done) begin
                    nxt_status    = bus.m_nack ? STAT_NACK : STAT_OK;
                    nxt_rdata     = (r_m_rw && !bus.m_nack) ? bus.m_rdata : '0;
                    nxt_rsp_valid = w_ptr_onehot;
                    nxt_state     = ST_RESP;
                end else if (r_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    nxt_abort     = 1'b1;
                    nxt_status    = STAT_TIMEOUT;
                    nxt_rdata     = '0;
                    nxt_rsp_valid = w_ptr_onehot;
                    nxt_state     = ST_RESP;
                end else begin
                    if (r_cnt != {TO_W{1'b1}}) begin
                        nxt_cnt = r_cnt + TO_W'(1);
                    end
                    if ((r_state == ST_WAIT_BUSY) && bus.m_busy) begin
                        nxt_state = ST_WAIT_DONE;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready[r_ptr]) begin
                    nxt_rsp_valid = '0;
                    nxt_state     = ST_IDLE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    assign bus.req_gnt    = r_gnt;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rdata;
    assign bus.rsp_status = r_status;
    assign bus.m_start    = r_start;
    assign bus.m_addr     = r_m_addr;
    assign bus.m_rw       = r_m_rw;
    assign bus.m_wdata    = r_m_wdata;
    assign bus.m_abort    = r_abort;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_i2c_txn_arbiter;

    localparam int unsigned NREQ = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    i2c_txn_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    i2c_txn_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (16),
        .TO_W           (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        bus.req_addr[idx*7 +: 7]  = a;
        bus.req_rw[idx]           = rw;
        bus.req_wdata[idx*8 +: 8] = wd;
    endtask

    // Requests already driven while idle: expect grant, then m_start, then engine goes busy.
    task automatic launch(input int idx, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        tick();
        chk("gnt", 32'(bus.req_gnt), 32'(1) << idx);
        chk("start_after_gnt_low", 32'(bus.m_start), 0);
        tick();
        chk("gnt_pulse", 32'(bus.req_gnt), 0);
        chk("m_start", 32'(bus.m_start), 1);
        chk("m_addr", 32'(bus.m_addr), 32'(a));
        chk("m_rw", 32'(bus.m_rw), 32'(rw));
        chk("m_wdata", 32'(bus.m_wdata), 32'(wd));
        bus.m_busy = 1'b1;
        tick();
        chk("start_pulse", 32'(bus.m_start), 0);
    endtask

    task automatic engine_finish(input logic nack, input logic [7:0] rd);
        bus.m_done  = 1'b1;
        bus.m_nack  = nack;
        bus.m_rdata = rd;
        bus.m_busy  = 1'b0;
        tick();
        bus.m_done  = 1'b0;
        bus.m_nack  = 1'b0;
        bus.m_rdata = 8'h00;
    endtask

    task automatic respond(input int idx, input logic [7:0] rd, input logic [1:0] st);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << idx);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rd));
        chk("rsp_status", 32'(bus.rsp_status), 32'(st));
        bus.rsp_ready = NREQ'(1) << idx;
        tick();
        chk("rsp_valid_clr", 32'(bus.rsp_valid), 0);
        bus.rsp_ready = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bus.req_gnt), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rdata"}, 32'(bus.rsp_rdata), 0);
        chk({tag, "_status"}, 32'(bus.rsp_status), 0);
        chk({tag, "_m_start"}, 32'(bus.m_start), 0);
        chk({tag, "_m_abort"}, 32'(bus.m_abort), 0);
        chk({tag, "_m_addr"}, 32'(bus.m_addr), 0);
        chk({tag, "_m_rw"}, 32'(bus.m_rw), 0);
        chk({tag, "_m_wdata"}, 32'(bus.m_wdata), 0);
    endtask

    initial begin
        int early;
        n_cmp = 0;
        n_err = 0;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_rw    = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = '0;
        bus.m_busy    = 1'b0;
        bus.m_done    = 1'b0;
        bus.m_nack    = 1'b0;
        bus.m_rdata   = 8'h00;

        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        chk("idle_no_gnt", 32'(bus.req_gnt), 0);

        // Single write from requester 0.
        set_req(0, 7'h50, 1'b0, 8'hA5);
        bus.req_valid = 4'b0001;
        launch(0, 7'h50, 1'b0, 8'hA5);
        bus.req_valid = '0;
        tick();
        engine_finish(1'b0, 8'hEE);
        respond(0, 8'h00, 2'b00);

        // Read from requester 2, response held while ready is low (other readies ignored).
        set_req(2, 7'h3C, 1'b1, 8'h00);
        bus.req_valid = 4'b0100;
        launch(2, 7'h3C, 1'b1, 8'h00);
        bus.req_valid = '0;
        tick();
        tick();
        engine_finish(1'b0, 8'h7E);
        bus.rsp_ready = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(bus.rsp_valid), 32'h4);
            chk("hold_rdata", 32'(bus.rsp_rdata), 32'h7E);
            chk("hold_status", 32'(bus.rsp_status), 0);
        end
        bus.rsp_ready = '0;
        respond(2, 8'h7E, 2'b00);

        // NACK on a read from requester 1: rdata forced to zero.
        set_req(1, 7'h22, 1'b1, 8'h00);
        bus.req_valid = 4'b0010;
        launch(1, 7'h22, 1'b1, 8'h00);
        bus.req_valid = '0;
        engine_finish(1'b1, 8'h99);
        respond(1, 8'h00, 2'b01);

        // Timeout: engine busy, never done; abort follows the 16th wait cycle.
        set_req(3, 7'h11, 1'b0, 8'h5A);
        bus.req_valid = 4'b1000;
        launch(3, 7'h11, 1'b0, 8'h5A);
        bus.req_valid = '0;
        early = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.m_abort || (bus.rsp_valid != 0)) early++;
        end
        chk("no_early_abort", 32'(early), 0);
        tick();
        chk("m_abort", 32'(bus.m_abort), 1);
        bus.m_busy = 1'b0;
        respond(3, 8'h00, 2'b10);
        chk("abort_pulse", 32'(bus.m_abort), 0);

        // m_done on the timeout cycle wins: OK status, no abort; write returns zero rdata.
        set_req(0, 7'h12, 1'b0, 8'h34);
        bus.req_valid = 4'b0001;
        launch(0, 7'h12, 1'b0, 8'h34);
        bus.req_valid = '0;
        for (int i = 0; i < 14; i++) tick();
        chk("pre_done_no_abort", 32'(bus.m_abort), 0);
        engine_finish(1'b0, 8'hCC);
        chk("done_wins_no_abort", 32'(bus.m_abort), 0);
        respond(0, 8'h00, 2'b00);

        // Reset in WAIT_DONE; req1 pending afterwards wins from a fresh pointer.
        set_req(2, 7'h33, 1'b1, 8'h00);
        bus.req_valid = 4'b0100;
        launch(2, 7'h33, 1'b1, 8'h00);
        bus.req_valid = '0;
        tick();
        tick();
        reset         = 1'b1;
        bus.m_busy    = 1'b0;
        bus.req_valid = 4'b0010;
        tick();
        chk_all_zero("midrst");
        reset = 1'b0;
        launch(1, 7'h22, 1'b1, 8'h00);
        bus.req_valid = '0;
        engine_finish(1'b0, 8'h5C);
        respond(1, 8'h5C, 2'b00);

        // Round-robin with all requesters valid continuously, after a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 7'(8'h10 + i), 1'b0, 8'(8'h20 + i));
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            launch(i % 4, 7'(8'h10 + (i % 4)), 1'b0, 8'(8'h20 + (i % 4)));
            engine_finish(1'b0, 8'h00);
            respond(i % 4, 8'h00, 2'b00);
        end
        bus.req_valid = '0;
        tick();
        tick();
        chk("final_no_gnt", 32'(bus.req_gnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one I2C byte-transfer engine (START / ADDRESS / ACK / DATA / ACK2 / STOP sequencer) between NUM_REQ system-side requesters.
- Arbitrates round-robin, launches one single-byte transaction at a time, and supervises it with a timeout.
- Returns read data and a completion status to the winning requester over a valid/ready response handshake.
- Sits in the system clock domain, between the requester blocks and the I2C engine's command interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, clk cycles allowed from engine start to m_done before abort.
- TO_W, 13, timeout counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_addr  in  NUM_REQ*7  7-bit slave address per requester.
- req_rw  in  NUM_REQ  0 = write, 1 = read.
- req_wdata  in  NUM_REQ*8  write byte per requester.
- req_gnt  out  NUM_REQ  one-hot, 1-cycle pulse: command accepted.
- rsp_valid  out  NUM_REQ  one-hot: response pending for that requester.
- rsp_ready  in  NUM_REQ  requester consumes the response.
- rsp_rdata  out  8  read byte; 0 for writes and errors.
- rsp_status  out  2  00 OK, 01 NACK, 10 TIMEOUT.
- m_start  out  1  1-cycle pulse launching the engine.
- m_addr  out  7  latched address to engine.
- m_rw  out  1  latched direction to engine.
- m_wdata  out  8  latched write byte to engine.
- m_abort  out  1  1-cycle pulse forcing the engine to STOP/IDLE.
- m_busy  in  1  engine is not in IDLE.
- m_done  in  1  1-cycle pulse: transaction finished.
- m_nack  in  1  valid with m_done: slave NACKed address or data.
- m_rdata  in  8  valid with m_done when read.

Behaviour:
- Reset values: every output 0. State = IDLE. RR pointer = NUM_REQ-1, so requester 0 has first priority. Timeout counter = 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - When any req_valid=1 and m_busy=0, pick the first set bit searching from ptr+1 with wrap-around.
  - Assert req_gnt[i] for one cycle, latch addr/rw/wdata into the m_* registers, set ptr=i, go to ISSUE.
  - While m_busy=1, issue nothing.
- ISSUE: m_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - m_busy=1 → WAIT_DONE.
  - m_done in this state (fast engine) is handled as in WAIT_DONE.
  - The timeout counter runs in both wait states.
- WAIT_DONE:
  - On m_done: capture status (m_nack ? 01 : 00) and rdata (m_rw & ~m_nack ? m_rdata : 0); go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without m_done: pulse m_abort for one cycle, status=10, rdata=0, go to RESP.
  - m_done and timeout in the same cycle: m_done wins; no abort.
- RESP:
  - rsp_valid[ptr]=1; rsp_rdata and rsp_status held stable until rsp_ready[ptr]=1.
  - Handshake cycle: clear rsp_valid → IDLE. A new grant can occur at the earliest on the next cycle.
  - rsp_ready bits of other requesters are ignored.
- Latency: grant to m_start = 1 cycle. m_done to rsp_valid = 1 cycle.
- Only one transaction is outstanding. req_valid must stay high until gnt; commands dropped before grant are not issued.
- m_addr/m_rw/m_wdata hold their values from grant until the next grant.
- Reset asserted mid-transaction: return to IDLE and clear all outputs. m_abort is not pulsed; the engine shares the same reset.
- Counter saturates and never wraps. TO_W is checked by an elaboration-time assertion.

Decomposition:
- Shared package i2c_pkg:
  - typedef enum for the arbiter states.
  - Status encodings STAT_OK, STAT_NACK, STAT_TIMEOUT.
  - I2C address width constant (7).
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Combinational, so it can be reused by other shared-bus controllers.

Test Plan:
- Single write: req0 addr=0x50, rw=0, wdata=0xA5; engine returns m_done with m_nack=0 → gnt[0] pulse, m_start 1 cycle later with m_addr=0x50, m_wdata=0xA5; rsp_valid[0], status=00, rdata=0x00.
- Read: req2 addr=0x3C, rw=1; m_done with m_rdata=0x7E → rsp_valid[2], rdata=0x7E, status=00; held 5 cycles with rsp_ready=0, unchanged until ready.
- Round-robin: req_valid=4'b1111 held continuously → grant order 0,1,2,3,0; no requester granted twice before the others are served.
- NACK: m_done with m_nack=1 on a read → status=01, rdata=0x00.
- Timeout: TIMEOUT_CYCLES=16, m_busy=1 and no m_done → m_abort pulse on the 16th wait cycle, status=10. Second case: m_done arriving on the same cycle as the timeout → status=00 and no m_abort.
- Reset mid-op: reset asserted in WAIT_DONE → all outputs 0 next cycle, state IDLE; req1 pending afterwards → next grant is to req0 only if req0 is valid, otherwise req1.
